// File: rtl/pc_fetch_ctrl_pkg.sv
// rtl/pc_fetch_ctrl_pkg.sv - shared state encodings and constants for the fetch PC generator
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSN_BYTES       = 32'd4;

  // Jump targets never carry bit0 into the PC.
  function automatic logic [31:0] mask_target(input logic [31:0] target);
    return {target[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_pc_next_mux.sv
// rtl/pc_fetch_ctrl_pc_next_mux.sv - next-PC priority select: redirect target, hold, or sequential
module pc_next_mux
  import pc_fetch_ctrl_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] target_i,
  input  logic        redirect_i,
  input  logic        hold_i,
  output logic [31:0] pc_next_o,
  output logic [31:0] pc4_o
);

  assign pc4_o = pc_i + INSN_BYTES;

  always_comb begin
    pc_next_o = pc4_o;
    if (redirect_i) begin
      pc_next_o = mask_target(target_i);
    end else if (hold_i) begin
      pc_next_o = pc_i;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch-stage PC register with EX redirect, stall hold and flush pulses
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             ex_valid,
  input  logic             pc_Sel,
  input  logic [31:0]      target_ex,
  input  logic             stall_if,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc4_o,
  output logic             fetch_valid,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redirect;
  logic             hold;

  assign redirect = ex_valid & pc_Sel;
  // The boot bubble keeps RESET_PC for one extra cycle while the ROM settles.
  assign hold     = stall_if | (state_q == S_BOOT);

  pc_next_mux u_pc_next_mux (
    .pc_i       (pc_q),
    .target_i   (target_ex),
    .redirect_i (redirect),
    .hold_i     (hold),
    .pc_next_o  (pc_d),
    .pc4_o      (pc4_o)
  );

  always_comb begin
    state_d     = state_q;
    fetch_valid = 1'b0;
    case (state_q)
      S_BOOT: begin
        fetch_valid = 1'b0;
        state_d     = redirect ? S_FLUSH : S_RUN;
      end
      S_RUN, S_FLUSH: begin
        fetch_valid = 1'b1;
        state_d     = redirect ? S_FLUSH : S_RUN;
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    misalign_d = misalign_q | (redirect & target_ex[1]);
    cnt_d      = cnt_q;
    if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_o         = pc_q;
  assign if_id_flush  = redirect & ~cpu_rst;
  assign id_ex_flush  = redirect & ~cpu_rst;
  assign misalign_err = misalign_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch-stage PC generator; the direct downstream consumer of the branch-decision stage.
- Holds the architectural fetch PC and applies the EX-stage redirect (pc_Sel plus target).
- Honours hazard stalls and emits one-cycle flush pulses to the IF/ID and ID/EX pipeline registers.
- Feeds the instruction ROM address and the IF/ID register; keeps a sticky misaligned-target flag and a saturating redirect counter for trace debug.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- CNT_W, 16, width of redirect counter

Ports:
- cpu_clk  in  1  clock, all state updates on rising edge
- cpu_rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction
- pc_Sel  in  1  branch/jump taken, from branch-decision stage (EX)
- target_ex  in  32  branch/jump target computed in EX
- stall_if  in  1  load-use hazard: hold PC and IF/ID
- pc_o  out  32  current fetch PC (ROM address)
- pc4_o  out  32  pc_o + 4
- fetch_valid  out  1  pc_o is a live fetch this cycle
- if_id_flush  out  1  clear IF/ID next edge
- id_ex_flush  out  1  clear ID/EX next edge
- misalign_err  out  1  sticky: a taken target had bit1 set
- redirect_cnt  out  CNT_W  number of redirects taken, saturating

Behaviour:
- Reset, while cpu_rst is high at an edge:
  - state=S_BOOT, pc_o=RESET_PC.
  - fetch_valid=0, if_id_flush=0, id_ex_flush=0, misalign_err=0, redirect_cnt=0.
  - Reset mid-operation discards any redirect or stall in the same cycle.
- redirect = ex_valid & pc_Sel. Computed combinationally; pc_Sel is ignored when ex_valid=0.
- Effective target: {target_ex[31:1],1'b0}. Bit0 is forced to 0 (jalr rule).
- States:
  - S_BOOT: fetch_valid=0. Next edge → S_RUN with pc_o unchanged (=RESET_PC). Gives one bubble after reset for ROM settle.
  - S_RUN: fetch_valid=1.
    - redirect → pc_o<=effective target, state→S_FLUSH.
    - else if stall_if → pc_o held.
    - else pc_o<=pc_o+4.
  - S_FLUSH: fetch_valid=1; pc_o is the target being fetched. Same next-PC rules as S_RUN, then → S_RUN (or stay in S_FLUSH if a fresh redirect occurs).
- Flush outputs are combinational from redirect, so they are valid in the same cycle as pc_Sel: if_id_flush=redirect, id_ex_flush=redirect.
- Priority: cpu_rst > redirect > stall_if > sequential increment.
  - Redirect during stall_if: redirect wins, PC moves to target, both flushes assert.
- Arithmetic: pc_o+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- misalign_err: set on any redirect with target_ex[1]=1, then sticky until reset. The redirect is still taken.
- redirect_cnt: increments on each redirect; saturates at all-ones.
- S_BOOT with ex_valid=1: cannot occur after reset. If forced, redirect still applies and the state goes → S_FLUSH.
- Latency: pc_Sel at cycle N → pc_o=target at N+1; instruction at target reaches ID at N+2.

Decomposition:
- Shared package/define file: state encodings S_BOOT=2'd0, S_RUN=2'd1, S_FLUSH=2'd2; RESET_PC default; INSN_BYTES=4.
- One natural sub-module: pc_next_mux. Combinational priority select of target, hold or pc+4 plus bit0 masking; lets priority be unit-tested alone.
- Counter and sticky flag stay inline.

Test Plan:
- Reset release, no stalls → pc_o: 0 (fetch_valid=0), 0 (fetch_valid=1), 4, 8, 0xC.
- At pc_o=0x10: ex_valid=1, pc_Sel=1, target_ex=0x40 → if_id_flush=id_ex_flush=1 that cycle; next pc_o=0x40; redirect_cnt=1; then 0x44.
- stall_if=1 for 3 cycles at pc_o=0x20 → pc_o stays 0x20; no flushes. Release → 0x24.
- stall_if=1 and redirect together, target_ex=0x101 → pc_o=0x100 (bit0 masked); flushes=1; misalign_err stays 0.
- Redirect with target_ex=0x202 → pc_o=0x202, misalign_err=1 and stays 1 through later redirects until cpu_rst.
- pc_Sel=1 with ex_valid=0 → ignored, pc_o increments, no flush. Then assert cpu_rst during S_FLUSH → next edge pc_o=RESET_PC, state S_BOOT, redirect_cnt=0.
